// File: rtl/coherence_broadcaster.sv
// Purpose : per-cache write-notify FIFOs, round-robin drained, one invalidate broadcast per cycle to all caches but the writer.
// Latency : notify accepted at edge E into an empty, winning FIFO -> inv_valid high in the cycle after edge E+1.
// Backpres: change_ready[i] = !full from registered occupancy; notifies offered while not ready are dropped and counted.
//
// Ports:
//   clock, reset (async, active-low)
//   change_valid/change_addr/change_ready : per-cache write-notify input, slice i of change_addr belongs to cache i
//   inv_valid/inv_addr/inv_src            : registered broadcast, inv_valid masks out the writer's own bit
//   pending                               : per-source FIFO non-empty
//   overflow_cnt                          : saturating count of dropped notifies
// Build option: define COH_DEDUP_EN to suppress a notify whose address matches the
// source's last enqueued address while that entry is still queued.
module coherence_broadcaster #(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SRC_W      = $clog2(NUM_CACHES)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CACHES-1:0]        change_valid,
    input  logic [NUM_CACHES*ADDR_W-1:0] change_addr,
    output logic [NUM_CACHES-1:0]        change_ready,
    output logic [NUM_CACHES-1:0]        inv_valid,
    output logic [ADDR_W-1:0]            inv_addr,
    output logic [SRC_W-1:0]             inv_src,
    output logic [NUM_CACHES-1:0]        pending,
    output logic [7:0]                   overflow_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem    [NUM_CACHES][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CACHES];
    logic [PTR_W-1:0]  rd_ptr [NUM_CACHES];
    logic [CNT_W-1:0]  count  [NUM_CACHES];

    logic [NUM_CACHES-1:0] full;
    logic [NUM_CACHES-1:0] push;
    logic [NUM_CACHES-1:0] pop;
    logic [NUM_CACHES-1:0] drop;
    logic [NUM_CACHES-1:0] dup;

    logic [SRC_W-1:0] rr_ptr;
    logic             grant_vld;
    logic [SRC_W-1:0] grant_idx;

    logic [3:0] n_drop;
    logic [8:0] ovf_sum;
    logic [7:0] ovf_next;

`ifdef COH_DEDUP_EN
    logic [ADDR_W-1:0]     last_addr [NUM_CACHES];
    logic [NUM_CACHES-1:0] last_vld;
`endif

    // Occupancy-derived status, registered state only (ready is not pop-aware).
    always_comb begin
        full         = '0;
        change_ready = '0;
        pending      = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            full[i]         = (count[i] == CNT_W'(FIFO_DEPTH));
            change_ready[i] = !full[i];
            pending[i]      = (count[i] != '0);
        end
    end

    // Round-robin: first non-empty source searching upward from rr_ptr+1.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_CACHES; k++) begin
            int c;
            c = (int'(rr_ptr) + k) % NUM_CACHES;
            if (!grant_vld && pending[c]) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(c);
            end
        end
    end

    always_comb begin
        push   = '0;
        pop    = '0;
        drop   = '0;
        dup    = '0;
        n_drop = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
`ifdef COH_DEDUP_EN
            dup[i] = last_vld[i] && (last_addr[i] == change_addr[i*ADDR_W +: ADDR_W]);
`endif
            // A duplicate is still accepted (ready honoured), just not stored.
            push[i] = change_valid[i] && !full[i] && !dup[i];
            drop[i] = change_valid[i] && full[i];
            pop[i]  = grant_vld && (grant_idx == SRC_W'(i));
            n_drop  = n_drop + 4'(drop[i]);
        end
        ovf_sum  = {1'b0, overflow_cnt} + 9'(n_drop);
        ovf_next = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end

    // Storage needs no reset: validity is carried entirely by count.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= change_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CACHES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr       <= SRC_W'(NUM_CACHES - 1);
            overflow_cnt <= '0;
            inv_valid    <= '0;
            inv_addr     <= '0;
            inv_src      <= '0;
        end else begin
            for (int i = 0; i < NUM_CACHES; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            overflow_cnt <= ovf_next;
            if (grant_vld) begin
                rr_ptr    <= grant_idx;
                inv_valid <= ~(NUM_CACHES'(1) << grant_idx);
                inv_addr  <= mem[grant_idx][rd_ptr[grant_idx]];
                inv_src   <= grant_idx;
            end else begin
                inv_valid <= '0;
            end
        end
    end

`ifdef COH_DEDUP_EN
    // The last-enqueued entry is the tail, so it leaves when it is popped as the sole entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_vld <= '0;
            for (int i = 0; i < NUM_CACHES; i++) last_addr[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CACHES; i++) begin
                if (push[i]) begin
                    last_vld[i]  <= 1'b1;
                    last_addr[i] <= change_addr[i*ADDR_W +: ADDR_W];
                end else if (pop[i] && count[i] == CNT_W'(1)) begin
                    last_vld[i]  <= 1'b0;
                end
            end
        end
    end
`endif

endmodule
